svm_mem_sequencer: RTL and testbench

//  Parametrised memory sequencer for the cascaded-SVM datapath.
//  - Loads one test vector (NUM_OF_PIXELS pixels) into the x_test buffer over a valid/ready stream.
//  - Walks every support vector, pixel by pixel, issuing buffer/SV-memory reads.
//  - Emits MAC strobes aligned to the memory read latency.
//  - Pulses decision_funct_en once, after the last product of the last SV.

---
 rtl/svm_mem_sequencer.sv | 143 ++++++++++++++
 tb/tb_svm_mem_sequencer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/svm_mem_sequencer.sv
// rtl/svm_mem_sequencer.sv - test-vector loader and SV/pixel read sequencer with MAC strobe pipe
module svm_mem_sequencer #(
    parameter int XLEN_PIXEL    = 8,
    parameter int NUM_OF_PIXELS = 784,
    parameter int NUM_OF_SV     = 10,
    parameter int RD_LATENCY    = 1,
    localparam int PA = $clog2(NUM_OF_PIXELS),
    localparam int SA = (NUM_OF_SV > 1) ? $clog2(NUM_OF_SV) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  pix_valid,
    input  logic [XLEN_PIXEL-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  we,
    output logic [PA-1:0]         wr_addr,
    output logic [XLEN_PIXEL-1:0] wr_data,
    output logic                  re,
    output logic [SA-1:0]         sv_idx,
    output logic [PA-1:0]         pix_idx,
    output logic                  mac_valid,
    output logic                  mac_first,
    output logic                  mac_last,
    output logic                  stall_MEM,
    output logic                  decision_funct_en,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [PA-1:0] PIX_LAST   = PA'(NUM_OF_PIXELS - 1);
    localparam logic [SA-1:0] SV_LAST    = SA'(NUM_OF_SV - 1);
    localparam logic [2:0]    DRAIN_LAST = 3'(RD_LATENCY - 1);

    state_t          state, state_d;
    logic [PA-1:0]   cnt, cnt_d;
    logic [SA-1:0]   sv_cnt, sv_d;
    logic [2:0]      drain_cnt, drain_d;
    logic [2:0]      tap;
    logic [RD_LATENCY-1:0][2:0] pipe;

    // cnt is the load address in LOAD and the pixel index in READ
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            sv_cnt    <= '0;
            drain_cnt <= '0;
            pipe      <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            sv_cnt    <= sv_d;
            drain_cnt <= drain_d;
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                pipe[i] <= pipe[i-1];
            end
            pipe[0] <= tap;
        end
    end

    always_comb begin
        state_d           = state;
        cnt_d             = cnt;
        sv_d              = sv_cnt;
        drain_d           = drain_cnt;
        pix_ready         = 1'b0;
        stall_MEM         = 1'b0;
        we                = 1'b0;
        re                = 1'b0;
        decision_funct_en = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_d = '0;
                sv_d  = '0;
                if (en) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                pix_ready = 1'b1;
                stall_MEM = 1'b1;
                if (pix_valid) begin
                    we = 1'b1;
                    if (cnt == PIX_LAST) begin
                        cnt_d   = '0;
                        state_d = S_READ;
                    end else begin
                        cnt_d = cnt + PA'(1);
                    end
                end
            end
            S_READ: begin
                if (en) begin
                    re = 1'b1;
                    if (cnt == PIX_LAST) begin
                        cnt_d = '0;
                        if (sv_cnt == SV_LAST) begin
                            sv_d    = '0;
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            sv_d = sv_cnt + SA'(1);
                        end
                    end else begin
                        cnt_d = cnt + PA'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = drain_cnt + 3'd1;
                end
            end
            S_DONE: begin
                decision_funct_en = 1'b1;
                state_d           = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tap       = {re, re && (cnt == '0), re && (cnt == PIX_LAST)};
    assign mac_valid = pipe[RD_LATENCY-1][2];
    assign mac_first = pipe[RD_LATENCY-1][1];
    assign mac_last  = pipe[RD_LATENCY-1][0];

    assign wr_addr = (state == S_LOAD) ? cnt : '0;
    assign wr_data = pix_data;
    assign pix_idx = (state == S_READ) ? cnt : '0;
    assign sv_idx  = sv_cnt;
    assign busy    = (state != S_IDLE);

endmodule

// File: tb/tb_svm_mem_sequencer.sv
// tb/tb_svm_mem_sequencer.sv - directed self-checking bench, N=4 S=2 with L=1 and L=3 instances
module tb_svm_mem_sequencer;

    logic       clk = 1'b0;
    logic       rst, en, pix_valid;
    logic [7:0] pix_data;

    logic       pix_ready_a, we_a, re_a, mv_a, mf_a, ml_a, stall_a, dec_a, busy_a;
    logic [1:0] wr_addr_a, pix_idx_a;
    logic [0:0] sv_idx_a;
    logic [7:0] wr_data_a;
    logic       pix_ready_b, we_b, re_b, mv_b, mf_b, ml_b, stall_b, dec_b, busy_b;
    logic [1:0] wr_addr_b, pix_idx_b;
    logic [0:0] sv_idx_b;
    logic [7:0] wr_data_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    svm_mem_sequencer #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(4), .NUM_OF_SV(2), .RD_LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready_a), .we(we_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .re(re_a), .sv_idx(sv_idx_a), .pix_idx(pix_idx_a),
        .mac_valid(mv_a), .mac_first(mf_a), .mac_last(ml_a),
        .stall_MEM(stall_a), .decision_funct_en(dec_a), .busy(busy_a)
    );

    svm_mem_sequencer #(.XLEN_PIXEL(8), .NUM_OF_PIXELS(4), .NUM_OF_SV(2), .RD_LATENCY(3)) u_l3 (
        .clk(clk), .rst(rst), .en(en), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready_b), .we(we_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .re(re_b), .sv_idx(sv_idx_b), .pix_idx(pix_idx_b),
        .mac_valid(mv_b), .mac_first(mf_b), .mac_last(ml_b),
        .stall_MEM(stall_b), .decision_funct_en(dec_b), .busy(busy_b)
    );

    wire [8:0] fa = {pix_ready_a, we_a, re_a, mv_a, mf_a, ml_a, stall_a, dec_a, busy_a};
    wire [8:0] fb = {pix_ready_b, we_b, re_b, mv_b, mf_b, ml_b, stall_b, dec_b, busy_b};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int px, rd, re_cnt, dec_cnt;
        logic [2:0] ea, eb;

        // reset held with en and pix_valid high
        rst = 1'b1; en = 1'b1; pix_valid = 1'b1; pix_data = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("rst_flags_l1", fa, 0);
            chk("rst_flags_l3", fb, 0);
            chk("rst_idx", {wr_addr_a, sv_idx_a, pix_idx_a}, 0);
        end

        // basic run: start pulse, 4 pixels back-to-back, 8 reads
        @(negedge clk); rst = 1'b0; en = 1'b1; pix_valid = 1'b0; #1;
        chk("idle_busy", busy_a, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); en = 1'b0; pix_valid = 1'b1; pix_data = 8'(10 + i); #1;
            chk("ld_flags", fa, 9'b110000101);
            chk("ld_addr", wr_addr_a, i);
            chk("ld_data", wr_data_a, 10 + i);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); en = 1'b1; pix_valid = 1'b0; #1;
            chk("rd_re", {re_a, stall_a}, 2'b10);
            chk("rd_idx", {sv_idx_a, pix_idx_a}, k);
            ea = (k > 0) ? {1'b1, ((k - 1) % 4 == 0), ((k - 1) % 4 == 3)} : 3'b000;
            eb = (k > 2) ? {1'b1, ((k - 3) % 4 == 0), ((k - 3) % 4 == 3)} : 3'b000;
            chk("rd_mac_l1", {mv_a, mf_a, ml_a}, ea);
            chk("rd_mac_l3", {mv_b, mf_b, ml_b}, eb);
        end
        for (int j = 0; j < 5; j++) begin
            @(negedge clk); en = (j == 1); pix_valid = 1'b0; #1;
            chk("tail_l1", {re_a, mv_a, mf_a, ml_a, dec_a, busy_a},
                {1'b0, (j == 0), 1'b0, (j == 0), (j == 1), (j < 2)});
            chk("tail_l3", {re_b, mv_b, mf_b, ml_b, dec_b, busy_b},
                {1'b0, (j < 3), 1'b0, (j == 2), (j == 3), (j < 4)});
        end

        // load with a 2-cycle pix_valid gap, then reads with a 3-cycle en gap
        @(negedge clk); en = 1'b1; pix_valid = 1'b0; #1;
        px = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); en = 1'b0; pix_valid = (c != 2 && c != 3); pix_data = 8'(20 + px); #1;
            chk("gap_stall", {stall_a, pix_ready_a}, 2'b11);
            chk("gap_we", we_a, pix_valid);
            chk("gap_addr", wr_addr_a, px);
            if (pix_valid) px++;
        end
        rd = 0; re_cnt = 0;
        for (int c = 0; c < 11; c++) begin
            @(negedge clk); en = !(c >= 2 && c <= 4); #1;
            chk("hold_re", re_a, en);
            chk("hold_idx", {sv_idx_a, pix_idx_a}, rd);
            re_cnt += int'(re_a);
            if (en) rd++;
        end
        dec_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); en = (c == 0); #1;
            re_cnt  += int'(re_a);
            dec_cnt += int'(dec_a);
        end
        chk("hold_re_total", re_cnt, 8);
        chk("hold_dec_count", dec_cnt, 1);
        chk("hold_idle", {busy_a, busy_b}, 2'b00);

        // reset during READ at (1,1)
        @(negedge clk); en = 1'b1; pix_valid = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); en = 1'b0; pix_valid = 1'b1; pix_data = 8'(30 + i); #1;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); en = 1'b1; pix_valid = 1'b0; #1;
        end
        @(negedge clk); rst = 1'b1; en = 1'b1; #1;
        chk("pre_rst_idx", {re_a, sv_idx_a, pix_idx_a}, 4'b1101);
        @(negedge clk); rst = 1'b0; en = 1'b0; pix_valid = 1'b1; #1;
        chk("post_rst_l1", fa, 0);
        chk("post_rst_l3", fb, 0);
        chk("post_rst_idx", {wr_addr_a, sv_idx_a, pix_idx_a}, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("post_rst_mac", {mv_a, mv_b}, 2'b00);
        end
        @(negedge clk); en = 1'b1; pix_valid = 1'b0; #1;
        @(negedge clk); en = 1'b0; pix_valid = 1'b1; pix_data = 8'd99; #1;
        chk("restart_ld", {we_a, wr_addr_a, wr_data_a}, {1'b1, 2'd0, 8'd99});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
